// File: rtl/norm_shift64.sv
// norm_shift64: two-stage post-add normalizer for a 54-bit significand.
// Ports: clk/rst_n; in_* valid/ready beat (sum, exp, sign);
//        out_* valid/ready beat (mant, exp, sign, zero/ovf/unf); busy.
module norm_shift64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [54:0] in_sum,
   input  logic [10:0] in_exp,
   input  logic        in_sign,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [53:0] out_mant,
   output logic [10:0] out_exp,
   output logic        out_sign,
   output logic        out_zero,
   output logic        out_ovf,
   output logic        out_unf,
   output logic        busy
);

   logic        a_valid_q;
   logic [53:0] a_sum_q;
   logic [10:0] a_exp_q;
   logic        a_sign_q;
   logic        a_carry_q;
   logic [5:0]  a_lz_q;
   logic [5:0]  lz_d;

   logic        b_valid_q;
   logic [53:0] mant_q, mant_d;
   logic [10:0] exp_q, exp_d;
   logic        sign_q;
   logic        zero_q, zero_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;

   logic        a_load;
   logic        b_load;
   logic [11:0] exp_p1;
   logic        is_carry, is_zero;
   logic        is_norm, is_unf;

   assign b_load   = a_valid_q && (!b_valid_q || out_ready);
   assign a_load   = !a_valid_q || b_load;
   assign in_ready = a_load;
   assign busy     = a_valid_q || b_valid_q;

   // Highest set bit wins: later iterations overwrite.
   always_comb begin
      lz_d = 6'd54;
      for (int i = 0; i < 54; i++) begin
         if (in_sum[i]) lz_d = 6'(53 - i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q <= 1'b0;
         a_sum_q   <= '0;
         a_exp_q   <= '0;
         a_sign_q  <= 1'b0;
         a_carry_q <= 1'b0;
         a_lz_q    <= '0;
      end else if (a_load) begin
         a_valid_q <= in_valid;
         a_sum_q   <= in_sum[53:0];
         a_exp_q   <= in_exp;
         a_sign_q  <= in_sign;
         a_carry_q <= in_sum[54];
         a_lz_q    <= lz_d;
      end
   end

   assign exp_p1   = {1'b0, a_exp_q} + 12'd1;
   assign is_carry = a_carry_q;
   assign is_zero  = !a_carry_q && (a_sum_q == '0);
   assign is_norm  = !a_carry_q && (a_sum_q != '0)
                     && ({5'd0, a_lz_q} < a_exp_q);
   assign is_unf   = !a_carry_q && (a_sum_q != '0)
                     && ({5'd0, a_lz_q} >= a_exp_q);

   always_comb begin
      mant_d = '0;
      exp_d  = '0;
      zero_d = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      unique case (1'b1)
         is_carry: begin
            // Exponent 2047 is reserved, so saturate there.
            if (exp_p1 >= 12'd2047) begin
               ovf_d = 1'b1;
               exp_d = 11'd2047;
            end else begin
               mant_d = {1'b1, a_sum_q[53:1]};
               exp_d  = exp_p1[10:0];
            end
         end
         is_zero: begin
            zero_d = 1'b1;
         end
         is_norm: begin
            mant_d = a_sum_q << a_lz_q;
            exp_d  = a_exp_q - {5'd0, a_lz_q};
         end
         is_unf: begin
            unf_d  = 1'b1;
            zero_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_valid_q <= 1'b0;
         mant_q    <= '0;
         exp_q     <= '0;
         sign_q    <= 1'b0;
         zero_q    <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else if (b_load) begin
         b_valid_q <= 1'b1;
         mant_q    <= mant_d;
         exp_q     <= exp_d;
         sign_q    <= a_sign_q;
         zero_q    <= zero_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end else if (out_ready) begin
         b_valid_q <= 1'b0;
      end
   end

   assign out_valid = b_valid_q;
   assign out_mant  = mant_q;
   assign out_exp   = exp_q;
   assign out_sign  = sign_q;
   assign out_zero  = zero_q;
   assign out_ovf   = ovf_q;
   assign out_unf   = unf_q;

endmodule

// File: tb/tb_norm_shift64.sv
// tb_norm_shift64: directed and randomized checks of norm_shift64
// against a behavioural normalization model with a scoreboard.
module tb_norm_shift64;

   typedef struct packed {
      logic [53:0] mant;
      logic [10:0] exp;
      logic        sign;
      logic        zero;
      logic        ovf;
      logic        unf;
   } res_t;

   typedef struct {
      res_t r;
      int   c;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [54:0] in_sum;
   logic [10:0] in_exp;
   logic        in_sign;
   logic        out_valid;
   logic        out_ready;
   logic [53:0] out_mant;
   logic [10:0] out_exp;
   logic        out_sign;
   logic        out_zero;
   logic        out_ovf;
   logic        out_unf;
   logic        busy;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   lat_en = 1'b0;
   bit   held = 1'b0;
   res_t held_val;
   sb_t  sbq[$];

   always #5 clk = ~clk;

   norm_shift64 dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_exp(in_exp), .in_sign(in_sign),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_mant(out_mant), .out_exp(out_exp),
      .out_sign(out_sign), .out_zero(out_zero),
      .out_ovf(out_ovf), .out_unf(out_unf), .busy(busy)
   );

   task automatic chk(input string tag, input logic [79:0] got,
                      input logic [79:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cyc %0d",
                  tag, got, exp, cyc);
      end
   endtask

   // Normalize by walking the leading one up to the hidden bit.
   function automatic res_t model(logic [54:0] s, logic [10:0] e,
                                  logic sg);
      res_t        r = '0;
      int          sh = 0;
      logic [54:0] m = s;
      r.sign = sg;
      if (s == 0) begin
         r.zero = 1'b1;
      end else if (s[54]) begin
         if (int'(e) + 1 >= 2047) begin
            r.ovf = 1'b1;
            r.exp = 11'd2047;
         end else begin
            r.mant = s[54:1];
            r.exp  = e + 11'd1;
         end
      end else begin
         while (!m[53]) begin
            m = m << 1;
            sh++;
         end
         if (sh >= int'(e)) begin
            r.unf  = 1'b1;
            r.zero = 1'b1;
         end else begin
            r.mant = m[53:0];
            r.exp  = e - 11'(sh);
         end
      end
      return r;
   endfunction

   function automatic res_t got_res();
      return {out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf};
   endfunction

   task automatic step(input logic v, input logic [54:0] s,
                       input logic [10:0] e, input logic sg,
                       input logic rdy, input bit use_xp,
                       input res_t xp, output bit acc);
      sb_t  ent;
      res_t g;
      in_valid  = v;
      in_sum    = s;
      in_exp    = e;
      in_sign   = sg;
      out_ready = rdy;
      #1;
      g = got_res();
      chk("busy", {79'd0, busy}, {79'd0, sbq.size() != 0});
      if (held) begin
         chk("hold_valid", {79'd0, out_valid}, 80'd1);
         if (out_valid) chk("hold_data", 80'(g), 80'(held_val));
      end
      held = 1'b0;
      if (out_valid) begin
         if (rdy) begin
            if (sbq.size() == 0) begin
               chk("spurious", {79'd0, out_valid}, 80'd0);
            end else begin
               ent = sbq.pop_front();
               chk("data", 80'(g), 80'(ent.r));
               if (lat_en) chk("latency", 80'(cyc - ent.c), 80'd2);
            end
         end else begin
            held     = 1'b1;
            held_val = g;
         end
      end
      acc = v && in_ready;
      if (acc) begin
         ent.r = use_xp ? xp : model(s, e, sg);
         ent.c = cyc;
         sbq.push_back(ent);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, a);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          a;
      int          nacc;
      int          k;
      int          cls;
      int          pos;
      logic [63:0] r64;
      logic [54:0] s;
      logic [10:0] e;
      res_t        xp;

      rst_n = 1'b0;
      in_valid = 1'b0; in_sum = '0; in_exp = '0;
      in_sign = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", {79'd0, out_valid}, 80'd0);
      chk("rst_busy", {79'd0, busy}, 80'd0);
      chk("rst_in_ready", {79'd0, in_ready}, 80'd1);
      chk("rst_outputs", 80'(got_res()), 80'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors with hand-derived results.
      lat_en = 1'b1;
      xp = '{mant: 54'h20_0000_0000_0000, exp: 11'd1024, sign: 1'b1,
             zero: 1'b0, ovf: 1'b0, unf: 1'b0};
      step(1'b1, 55'h40_0000_0000_0000, 11'd1023, 1'b1, 1'b1, 1'b1, xp, a);
      chk("first_accept", {79'd0, a}, 80'd1);
      xp = '{mant: 54'h20_0000_0000_0000, exp: 11'd1020, sign: 1'b0,
             zero: 1'b0, ovf: 1'b0, unf: 1'b0};
      step(1'b1, 55'h04_0000_0000_0000, 11'd1023, 1'b0, 1'b1, 1'b1, xp, a);
      xp = '{mant: '0, exp: '0, sign: 1'b1,
             zero: 1'b1, ovf: 1'b0, unf: 1'b0};
      step(1'b1, 55'd0, 11'd500, 1'b1, 1'b1, 1'b1, xp, a);
      xp = '{mant: '0, exp: '0, sign: 1'b0,
             zero: 1'b1, ovf: 1'b0, unf: 1'b1};
      step(1'b1, 55'd1, 11'd10, 1'b0, 1'b1, 1'b1, xp, a);
      xp = '{mant: '0, exp: 11'd2047, sign: 1'b0,
             zero: 1'b0, ovf: 1'b1, unf: 1'b0};
      step(1'b1, 55'h40_0000_0000_0000, 11'd2046, 1'b0, 1'b1, 1'b1, xp, a);
      idle(4);
      chk("directed_drained", 80'(sbq.size()), 80'd0);

      // Backpressure: only two beats fit while the output stalls.
      lat_en = 1'b0;
      nacc = 0;
      k = 1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 55'h20_0000_0000_0000, 11'(k), 1'b0, 1'b0, 1'b0, '0, a);
         if (a) begin nacc++; k++; end
      end
      chk("bp_accepted", 80'(nacc), 80'd2);
      #1;
      chk("bp_in_ready", {79'd0, in_ready}, 80'd0);
      chk("bp_out_exp", 80'(out_exp), 80'd1);
      for (int i = 0; i < 4; i++) begin
         chk("bp_seq_valid", {79'd0, out_valid}, 80'd1);
         chk("bp_seq_exp", 80'(out_exp), 80'(i + 1));
         step(k <= 4, 55'h20_0000_0000_0000, 11'(k), 1'b0, 1'b1,
              1'b0, '0, a);
         if (a) k++;
         #1;
      end
      idle(3);

      // Reset with two beats in flight.
      step(1'b1, 55'h20_0000_0000_0000, 11'd7, 1'b0, 1'b1, 1'b0, '0, a);
      step(1'b1, 55'h20_0000_0000_0000, 11'd8, 1'b0, 1'b1, 1'b0, '0, a);
      #1;
      chk("pre_rst_valid", {79'd0, out_valid}, 80'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", {79'd0, out_valid}, 80'd0);
      chk("midrst_busy", {79'd0, busy}, 80'd0);
      chk("midrst_outputs", 80'(got_res()), 80'd0);
      #1;
      rst_n = 1'b1;
      sbq.delete();
      held = 1'b0;
      idle(3);
      lat_en = 1'b1;
      step(1'b1, 55'h00_0000_0000_0003, 11'd100, 1'b1, 1'b1, 1'b0, '0, a);
      chk("post_rst_accept", {79'd0, a}, 80'd1);
      idle(3);
      lat_en = 1'b0;

      // Randomized traffic with random stalls.
      for (int i = 0; i < 3000; i++) begin
         cls = $urandom_range(0, 9);
         r64 = {$urandom, $urandom};
         if (cls == 0) begin
            s = '0;
         end else if (cls <= 2) begin
            s = {1'b1, r64[53:0]};
         end else begin
            pos = $urandom_range(0, 53);
            r64 = (r64 & ((64'd1 << pos) - 64'd1)) | (64'd1 << pos);
            s = r64[54:0];
         end
         case ($urandom_range(0, 3))
            0: e = 11'($urandom_range(0, 60));
            1: e = 11'($urandom_range(2040, 2047));
            default: e = 11'($urandom_range(0, 2047));
         endcase
         step($urandom_range(0, 3) != 0, s, e, 1'($urandom),
              $urandom_range(0, 3) != 0, 1'b0, '0, a);
      end
      for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(1);
      chk("final_drain", 80'(sbq.size()), 80'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
